hazard_log_writer: RTL and testbench
====================================

HAZARD_LOG_WRITER -- requirements
Module: hazard_log_writer

Interface
REQ-001 Parameter NUM_SLOTS SHALL default to 13; it is the number of 8-bit hazard records in the log.
REQ-002 Parameter TAG_W SHALL default to 3; it is the instruction-tag width and the register-address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 issue_valid  in  1  SHALL mean one instruction enters ID this cycle.
REQ-006 issue_rd, issue_rs1, issue_rs2  in  3 each  SHALL carry the destination and source register addresses.
REQ-007 issue_we  in  1  SHALL mean the issuing instruction writes issue_rd.
REQ-008 issue_use_rs2  in  1  SHALL mean issue_rs2 is read.
REQ-009 flush_req  in  1  SHALL request presentation of a non-empty log.
REQ-010 log_ack  in  1  SHALL be the consumer acknowledge of a presented log.
REQ-011 hazardMem  out  8*NUM_SLOTS (104)  SHALL be the flattened log; slot k occupies [8k+7:8k].
REQ-012 log_valid  out  1  SHALL mean hazardMem is frozen and ready to read.
REQ-013 log_count  out  4  SHALL give the number of filled slots, 0..13.
REQ-014 log_full  out  1  SHALL be high when log_count == NUM_SLOTS.
REQ-015 log_overflow  out  1  SHALL be a sticky flag marking that a hazard was dropped.

Function
REQ-016 Record format SHALL be: [7:5] consumer tag, [4:2] producer tag, [1:0] distance (01 = 1 instruction, 10 = 2 instructions); an empty slot SHALL be 8'h00.
REQ-017 A 3-bit tag counter SHALL advance by 1 per issue_valid and wrap 7->0; the issuing instruction takes the current tag.
REQ-018 A 2-entry history {tag, rd, we} SHALL shift on each issue_valid (d1 = previous issue, d2 = the one before); it SHALL NOT shift without issue_valid.
REQ-019 On issue_valid, a hazard SHALL be detected when a valid source (rs1 always; rs2 only if issue_use_rs2) equals the rd of a history entry with we=1.
REQ-020 Priority SHALL be d1 over d2, then rs1 over rs2; at most one record SHALL be written per issue.
REQ-021 Producer tag SHALL be the matching history tag, so consumer and producer fields always differ.
REQ-022 Each record SHALL be written to slot log_count, and log_count SHALL increment, in the cycle after detection (1-cycle latency).
REQ-023 FSM FILL: records are accepted; the block moves to HOLD when log_full, or when flush_req=1 and log_count>0.
REQ-024 flush_req with log_count==0 SHALL be ignored.
REQ-025 FSM HOLD: log_valid=1, hazardMem stays frozen, and detected hazards are dropped and set log_overflow.
REQ-026 log_ack in HOLD SHALL clear all slots to 0, clear log_count, and return the FSM to FILL on the next edge.
REQ-027 If a hazard is detected in the same cycle as log_ack, the new record SHALL be written to slot 0 and log_count SHALL become 1.
REQ-028 log_ack in FILL SHALL be ignored.
REQ-029 log_overflow SHALL clear only on an accepted log_ack or on reset.
REQ-030 A hazard detected in the cycle log_full rises SHALL be dropped and SHALL set log_overflow.
REQ-031 The history SHALL keep updating in HOLD, so that detection stays correct after the drain.

Reset
REQ-032 Reset assertion SHALL asynchronously force: hazardMem=0, log_count=0, log_full=0, log_valid=0, log_overflow=0, tag=0, history we bits=0, FSM=FILL.
REQ-033 Reset assertion in the middle of HOLD or FILL SHALL discard the log with no record emitted.
REQ-034 Reset deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-035 Issue tag0 rd=2 we=1, then tag1 rs1=2 -> next cycle slot0=8'b001_000_01 and log_count=1.
REQ-036 Issue rd=3 we=1, an unrelated instruction, then rs2=3 with use_rs2=1 -> slot0=8'b010_000_10.
REQ-037 Issue rd=4 we=1, then rd=4 we=1, then rs1=4 -> a single record with distance 01 whose producer is the second writer.
REQ-038 Produce 14 consecutive hazards -> log_full and log_valid after the 13th, 14th dropped, log_overflow=1; log_ack -> log_count=0, hazardMem=0, log_overflow=0.
REQ-039 Two records, flush_req, then log_ack in the same cycle as a new hazard -> log_valid drops, slot0 holds the new record, log_count=1.
REQ-040 Drive rst_n low while in HOLD with 5 records -> all outputs 0 immediately without a clock edge.

Source files
------------

// File: rtl/hazard_log_if.sv
// Issue-stage, flush/acknowledge and log-readout signals of the hazard log writer.
interface hazard_log_if #(
  parameter int NUM_SLOTS = 13,
  parameter int TAG_W     = 3
);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic                   issue_valid;
  logic [TAG_W-1:0]       issue_rd;
  logic [TAG_W-1:0]       issue_rs1;
  logic [TAG_W-1:0]       issue_rs2;
  logic                   issue_we;
  logic                   issue_use_rs2;
  logic                   flush_req;
  logic                   log_ack;
  logic [8*NUM_SLOTS-1:0] hazardMem;
  logic                   log_valid;
  logic [CNT_W-1:0]       log_count;
  logic                   log_full;
  logic                   log_overflow;

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2, issue_we, issue_use_rs2,
    output flush_req, log_ack,
    input  hazardMem, log_valid, log_count, log_full, log_overflow
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2, issue_we, issue_use_rs2,
    input  flush_req, log_ack,
    output hazardMem, log_valid, log_count, log_full, log_overflow
  );
endinterface

// File: rtl/hazard_log_writer.sv
// Detects RAW hazards against the last two issued instructions and appends
// {consumer tag, producer tag, distance} records to a fixed-size log.
module hazard_log_writer #(
  parameter int NUM_SLOTS = 13,
  parameter int TAG_W     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_log_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int MEM_W = 8 * NUM_SLOTS;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] h1_tag_q, h1_rd_q, h2_tag_q, h2_rd_q;
  logic             h1_we_q, h2_we_q;
  logic [MEM_W-1:0] mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             d1_hit, d2_hit, det;
  logic [7:0]       rec;

  always_comb begin
    d1_hit = h1_we_q && ((bus.issue_rs1 == h1_rd_q) ||
                         (bus.issue_use_rs2 && (bus.issue_rs2 == h1_rd_q)));
    d2_hit = h2_we_q && ((bus.issue_rs1 == h2_rd_q) ||
                         (bus.issue_use_rs2 && (bus.issue_rs2 == h2_rd_q)));
    det    = bus.issue_valid && (d1_hit || d2_hit);
    // The nearer producer wins; rs1/rs2 order cannot change the record.
    rec    = d1_hit ? {tag_q, h1_tag_q, 2'b01} : {tag_q, h2_tag_q, 2'b10};
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      FILL: begin
        if (det) begin
          mem_d[{cnt_q, 3'b000} +: 8] = rec;
          cnt_d = cnt_q + 1'b1;
        end
        if ((cnt_d == FULL_CNT) || (bus.flush_req && (cnt_q != '0))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.log_ack) begin
          state_d = FILL;
          mem_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          // A hazard arriving with the acknowledge starts the fresh log.
          if (det) begin
            mem_d[7:0] = rec;
            cnt_d      = CNT_W'(1);
          end
        end else if (det) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      mem_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // History keeps shifting in HOLD so detection is correct after the drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      h1_tag_q <= '0;
      h1_rd_q  <= '0;
      h1_we_q  <= 1'b0;
      h2_tag_q <= '0;
      h2_rd_q  <= '0;
      h2_we_q  <= 1'b0;
    end else if (bus.issue_valid) begin
      tag_q    <= tag_q + 1'b1;
      h1_tag_q <= tag_q;
      h1_rd_q  <= bus.issue_rd;
      h1_we_q  <= bus.issue_we;
      h2_tag_q <= h1_tag_q;
      h2_rd_q  <= h1_rd_q;
      h2_we_q  <= h1_we_q;
    end
  end

  assign bus.hazardMem    = mem_q;
  assign bus.log_count    = cnt_q;
  assign bus.log_full     = (cnt_q == FULL_CNT);
  assign bus.log_valid    = (state_q == HOLD);
  assign bus.log_overflow = ovf_q;
endmodule

// File: tb/tb_hazard_log_writer.sv
// Scenario bench for hazard_log_writer: records are predicted when issued and
// matched against the slot that appears when log_count advances.
module tb_hazard_log_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hazard_log_if #(.NUM_SLOTS(13), .TAG_W(3)) bus ();

  hazard_log_writer #(.NUM_SLOTS(13), .TAG_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         nb_cmp  = 0;
  int         nb_fail = 0;
  int         prev_cnt = 0;
  logic [2:0] tb_tag = 3'd0;
  logic [7:0] sb[$];

  function automatic logic [7:0] mk_rec(input logic [2:0] c, input logic [2:0] p,
                                        input logic [1:0] d);
    return {c, p, d};
  endfunction

  // Scoreboard consumer: a new record lands in slot log_count-1.
  always @(posedge clk) begin
    int         cur;
    logic [7:0] got;
    logic [7:0] exp;
    #1;
    cur = int'(bus.log_count);
    if ((cur != prev_cnt) && (cur != 0) && ((cur == prev_cnt + 1) || (cur == 1))) begin
      got = bus.hazardMem[8*(cur-1) +: 8];
      nb_cmp++;
      if (sb.size() == 0) begin
        nb_fail++;
        $display("FAIL sb_unexpected_record slot=%0d got=%h required=none", cur - 1, got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          nb_fail++;
          $display("FAIL sb_record slot=%0d got=%b required=%b", cur - 1, got, exp);
        end
      end
    end
    prev_cnt = cur;
  end

  initial begin
    #100000;
    $display("FAIL watchdog sim_time=%0t required=finish_before_timeout", $time);
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.issue_valid   = 1'b0;
    bus.issue_rd      = 3'd0;
    bus.issue_rs1     = 3'd0;
    bus.issue_rs2     = 3'd0;
    bus.issue_we      = 1'b0;
    bus.issue_use_rs2 = 1'b0;
    bus.flush_req     = 1'b0;
    bus.log_ack       = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    tb_tag = 3'd0;
    sb.delete();
  endtask

  task automatic issue(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic we, input logic use2, input logic ack);
    @(negedge clk);
    bus.issue_valid   = 1'b1;
    bus.issue_rd      = rd;
    bus.issue_rs1     = rs1;
    bus.issue_rs2     = rs2;
    bus.issue_we      = we;
    bus.issue_use_rs2 = use2;
    bus.log_ack       = ack;
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.log_ack     = 1'b0;
    tb_tag          = tb_tag + 3'd1;
  endtask

  task automatic pulse(input logic flush, input logic ack);
    @(negedge clk);
    bus.flush_req = flush;
    bus.log_ack   = ack;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    bus.log_ack   = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    nb_cmp += 6;
    if (bus.hazardMem !== 104'd0) begin nb_fail++; $display("FAIL rst_mem got=%h required=0", bus.hazardMem); end
    if (bus.log_count !== 4'd0) begin nb_fail++; $display("FAIL rst_count got=%0d required=0", bus.log_count); end
    if (bus.log_full !== 1'b0) begin nb_fail++; $display("FAIL rst_full got=%b required=0", bus.log_full); end
    if (bus.log_valid !== 1'b0) begin nb_fail++; $display("FAIL rst_valid got=%b required=0", bus.log_valid); end
    if (bus.log_overflow !== 1'b0) begin nb_fail++; $display("FAIL rst_ovf got=%b required=0", bus.log_overflow); end
    pulse(1'b1, 1'b0);
    if (bus.log_valid !== 1'b0) begin nb_fail++; $display("FAIL empty_flush_valid got=%b required=0", bus.log_valid); end
  endtask

  task automatic test_distance1();
    apply_reset();
    issue(3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_rec(3'd1, 3'd0, 2'b01));
    issue(3'd0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
    nb_cmp += 3;
    if (bus.log_count !== 4'd1) begin nb_fail++; $display("FAIL d1_count got=%0d required=1", bus.log_count); end
    if (bus.hazardMem[7:0] !== 8'b001_000_01) begin nb_fail++; $display("FAIL d1_slot0 got=%b required=00100001", bus.hazardMem[7:0]); end
    if (sb.size() != 0) begin nb_fail++; $display("FAIL d1_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_distance2();
    apply_reset();
    issue(3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    issue(3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk_rec(3'd2, 3'd0, 2'b10));
    issue(3'd0, 3'd6, 3'd3, 1'b0, 1'b1, 1'b0);
    nb_cmp += 3;
    if (bus.log_count !== 4'd1) begin nb_fail++; $display("FAIL d2_count got=%0d required=1", bus.log_count); end
    if (bus.hazardMem[7:0] !== 8'b010_000_10) begin nb_fail++; $display("FAIL d2_slot0 got=%b required=01000010", bus.hazardMem[7:0]); end
    if (sb.size() != 0) begin nb_fail++; $display("FAIL d2_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_priority();
    apply_reset();
    issue(3'd4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    issue(3'd4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_rec(3'd2, 3'd1, 2'b01));
    issue(3'd0, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    nb_cmp += 2;
    if (bus.log_count !== 4'd1) begin nb_fail++; $display("FAIL prio_count got=%0d required=1", bus.log_count); end
    if (sb.size() != 0) begin nb_fail++; $display("FAIL prio_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_idle_gap();
    apply_reset();
    issue(3'd1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    sb.push_back(mk_rec(3'd1, 3'd0, 2'b01));
    issue(3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    // rs2 matches a writer but is not read: no record.
    issue(3'd0, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    nb_cmp += 3;
    if (bus.log_count !== 4'd1) begin nb_fail++; $display("FAIL gap_count got=%0d required=1", bus.log_count); end
    if (bus.log_valid !== 1'b0) begin nb_fail++; $display("FAIL fill_ack_valid got=%b required=0", bus.log_valid); end
    if (sb.size() != 0) begin nb_fail++; $display("FAIL gap_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      if (i >= 1 && i <= 13) sb.push_back(mk_rec(tb_tag, tb_tag - 3'd1, 2'b01));
      issue(3'd1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0);
      if (i == 13) begin
        nb_cmp += 4;
        if (bus.log_count !== 4'd13) begin nb_fail++; $display("FAIL full_count got=%0d required=13", bus.log_count); end
        if (bus.log_full !== 1'b1) begin nb_fail++; $display("FAIL full_flag got=%b required=1", bus.log_full); end
        if (bus.log_valid !== 1'b1) begin nb_fail++; $display("FAIL full_valid got=%b required=1", bus.log_valid); end
        if (bus.log_overflow !== 1'b0) begin nb_fail++; $display("FAIL full_ovf_early got=%b required=0", bus.log_overflow); end
      end
    end
    nb_cmp += 2;
    if (bus.log_overflow !== 1'b1) begin nb_fail++; $display("FAIL full_ovf got=%b required=1", bus.log_overflow); end
    if (bus.log_count !== 4'd13) begin nb_fail++; $display("FAIL full_hold_count got=%0d required=13", bus.log_count); end
    pulse(1'b0, 1'b1);
    nb_cmp += 6;
    if (bus.log_count !== 4'd0) begin nb_fail++; $display("FAIL drain_count got=%0d required=0", bus.log_count); end
    if (bus.hazardMem !== 104'd0) begin nb_fail++; $display("FAIL drain_mem got=%h required=0", bus.hazardMem); end
    if (bus.log_overflow !== 1'b0) begin nb_fail++; $display("FAIL drain_ovf got=%b required=0", bus.log_overflow); end
    if (bus.log_valid !== 1'b0) begin nb_fail++; $display("FAIL drain_valid got=%b required=0", bus.log_valid); end
    if (bus.log_full !== 1'b0) begin nb_fail++; $display("FAIL drain_full got=%b required=0", bus.log_full); end
    if (sb.size() != 0) begin nb_fail++; $display("FAIL full_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_back_to_back_ack();
    apply_reset();
    issue(3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_rec(3'd1, 3'd0, 2'b01));
    issue(3'd3, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_rec(3'd2, 3'd1, 2'b01));
    issue(3'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    nb_cmp += 2;
    if (bus.log_valid !== 1'b1) begin nb_fail++; $display("FAIL flush_valid got=%b required=1", bus.log_valid); end
    if (bus.log_count !== 4'd2) begin nb_fail++; $display("FAIL flush_count got=%0d required=2", bus.log_count); end
    // Dropped in HOLD, but it still updates the history.
    issue(3'd6, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    nb_cmp += 2;
    if (bus.log_overflow !== 1'b1) begin nb_fail++; $display("FAIL hold_ovf got=%b required=1", bus.log_overflow); end
    if (bus.hazardMem[23:0] !== {8'd0, 8'b010_001_01, 8'b001_000_01}) begin
      nb_fail++; $display("FAIL hold_frozen got=%h required=005121", bus.hazardMem[23:0]);
    end
    sb.push_back(mk_rec(3'd4, 3'd3, 2'b01));
    issue(3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1);
    nb_cmp += 5;
    if (bus.log_valid !== 1'b0) begin nb_fail++; $display("FAIL ackhz_valid got=%b required=0", bus.log_valid); end
    if (bus.log_count !== 4'd1) begin nb_fail++; $display("FAIL ackhz_count got=%0d required=1", bus.log_count); end
    if (bus.hazardMem[15:0] !== {8'd0, 8'b100_011_01}) begin nb_fail++; $display("FAIL ackhz_mem got=%h required=008d", bus.hazardMem[15:0]); end
    if (bus.log_overflow !== 1'b0) begin nb_fail++; $display("FAIL ackhz_ovf got=%b required=0", bus.log_overflow); end
    if (sb.size() != 0) begin nb_fail++; $display("FAIL ackhz_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_reset_in_hold();
    apply_reset();
    issue(3'd1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk_rec(tb_tag, tb_tag - 3'd1, 2'b01));
      issue(3'd1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    end
    pulse(1'b1, 1'b0);
    nb_cmp += 2;
    if (bus.log_valid !== 1'b1) begin nb_fail++; $display("FAIL pre_rst_valid got=%b required=1", bus.log_valid); end
    if (bus.log_count !== 4'd5) begin nb_fail++; $display("FAIL pre_rst_count got=%0d required=5", bus.log_count); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    nb_cmp += 5;
    if (bus.hazardMem !== 104'd0) begin nb_fail++; $display("FAIL async_mem got=%h required=0", bus.hazardMem); end
    if (bus.log_count !== 4'd0) begin nb_fail++; $display("FAIL async_count got=%0d required=0", bus.log_count); end
    if (bus.log_valid !== 1'b0) begin nb_fail++; $display("FAIL async_valid got=%b required=0", bus.log_valid); end
    if (bus.log_full !== 1'b0) begin nb_fail++; $display("FAIL async_full got=%b required=0", bus.log_full); end
    if (sb.size() != 0) begin nb_fail++; $display("FAIL async_pending got=%0d required=0", sb.size()); end
    apply_reset();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_distance1();
    test_distance2();
    test_priority();
    test_idle_gap();
    test_full();
    test_back_to_back_ack();
    test_reset_in_hold();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nb_cmp, nb_fail);
    $finish;
  end
endmodule
